avg_channel_sequencer: RTL
==========================

# avg_channel_sequencer

Sequencer that time-shares one moving-average datapath among CH sample sources. It paces sampling with a programmable tick divider and pulls one sample per tick from the selected channel over a valid/ready handshake. Each sample goes to the averager as a one-cycle enable, and the averaged result is reported once the window has filled. It sits between the ADC channel front-ends and the averager; on every channel change it flushes the averager and restarts the warm-up count.

## Interface
- N, 32: sample/result width
- CH, 4: number of source channels (≥2)
- WINDOW, 256: samples required after a flush before results are valid
- DIV, 1000: clk cycles per sample tick; must satisfy DIV > LAT+3 (elaboration assertion)
- LAT, 2: averager cycles from avg_en until avg_q reflects that sample

- clk  in  1  10 MHz clock
- reset  in  1  synchronous, active-high
- ch_sel  in  $clog2(CH)  requested channel
- ch_sel_load  in  1  one-cycle strobe; latch ch_sel request
- ch_valid  in  CH  per-channel sample valid
- ch_data  in  CH*N  channel k's sample at bits [k*N +: N]
- ch_ready  out  CH  one-hot ready, only to the active channel
- avg_clr  out  1  averager reset pulse
- avg_en  out  1  averager enable pulse
- avg_din  out  N  sample to averager
- avg_q  in  N  averager output
- res_valid  out  1  one-cycle result strobe
- res_data  out  N  averaged result
- res_ch  out  $clog2(CH)  channel of res_data
- sample_miss  out  1  one-cycle pulse when a tick is dropped

## Operation
- Reset: state FLUSH, active channel 0, no pending switch, warm_cnt 0, divider 0. All outputs 0 while reset is high.
- FSM states:
  - FLUSH: avg_clr=1 for one cycle; warm_cnt←0; apply any pending channel → WAIT_TICK.
  - WAIT_TICK: on tick → FETCH.
  - FETCH: ch_ready[active]=1. On ch_valid[active]&ch_ready: capture ch_data slice → ISSUE. Remains in FETCH otherwise.
  - ISSUE: avg_en=1, avg_din=captured sample; warm_cnt saturating increment at WINDOW → SETTLE.
  - SETTLE: LAT cycles; on the last cycle capture avg_q. res_valid pulses if warm_cnt==WINDOW. Then → FLUSH if a switch is pending, else WAIT_TICK.
- Channel switch request: ch_sel_load with ch_sel<CH and ch_sel≠active sets pending. ch_sel≥CH or equal to active is ignored; a later load overwrites pending.
  - In WAIT_TICK or FETCH: go to FLUSH next cycle. In FETCH, ch_ready is forced 0 in the load cycle, so no transfer occurs.
  - In ISSUE or SETTLE: deferred; the in-flight result completes and is reported under the old res_ch.
- Tick divider: free-running 0..DIV-1, tick when count==DIV-1, unaffected by FLUSH. A tick seen in any state other than WAIT_TICK is discarded and sample_miss=1 that cycle. Load and tick in the same cycle: the switch wins and the tick is dropped, with sample_miss=1.

## Timing
- Handshake transfer at cycle T → avg_en at T+1 → SETTLE T+2..T+1+LAT → res_valid, res_data, res_ch at T+2+LAT, all registered.
- avg_clr is exactly one cycle: the first cycle after reset deasserts, and the cycle after a switch is taken.
- The first res_valid after a flush follows the WINDOW-th issued sample. Every later sample produces one result.
- ch_ready is a registered-state decode: high only in FETCH for the active channel, low in all other states.
- Reset mid-operation aborts any handshake, and no res_valid is emitted for the aborted sample.

## Structure
- Package avg_seq_pkg: state_t enum (FLUSH, WAIT_TICK, FETCH, ISSUE, SETTLE) and the width helper function for channel and count fields.
- Sub-module tick_divider (parameter DIV; ports clk, reset, tick).
- Top level holds the FSM, pending-switch register, warm_cnt ($clog2(WINDOW+1) bits), settle counter, and the data mux.

## Test plan
Bench parameters: CH=4, DIV=8, LAT=2, WINDOW=4; stub averager returns the sum of the last 4 samples.
- Reset release, channel 0 always valid with data 1,2,3,4,5 → avg_clr for 1 cycle at reset exit; no res_valid for the first 3 samples; res_data 10 then 14, res_ch=0.
- Transfer at cycle T → avg_en at T+1, res_valid at T+4, and ch_ready low outside FETCH.
- ch_sel_load=2 during SETTLE → old result reported with res_ch=0, then avg_clr, then ch_ready[2] and warm-up restart (4 samples before res_valid).
- ch_valid[0] held low for 10 cycles → stays in FETCH, sample_miss pulses at the next tick, and no avg_en until valid.
- ch_sel_load=5 or =active → ignored: no flush, results continue. Load coinciding with tick in WAIT_TICK → flush, sample_miss=1.
- Reset asserted in FETCH with ch_valid high → no transfer, all outputs 0, clean FLUSH on release.

Source files
------------

// File: rtl/avg_seq_pkg.sv
// Shared types and width helper for the channel-sequenced averager.
//   state_t : sequencer FSM states
//   fld_w   : bit width needed to hold values 0..n-1 (minimum 1)
package avg_seq_pkg;

   typedef enum logic [2:0] {
      FLUSH,
      WAIT_TICK,
      FETCH,
      ISSUE,
      SETTLE
   } state_t;

   function automatic int unsigned fld_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running sample-tick divider: counts 0..DIV-1, o_tick high on DIV-1.
//   clk    : clock
//   reset  : synchronous active-high reset, count returns to 0
//   o_tick : one-cycle tick, decode of the count register
module tick_divider
   import avg_seq_pkg::*;
#(
   parameter int unsigned DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);

   localparam int unsigned CW = fld_w(DIV);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (r_cnt == CW'(DIV - 1))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   assign o_tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/avg_channel_sequencer.sv
// Time-shares one moving-average datapath among CH sample sources.
// Pulls one sample per tick from the active channel, feeds the averager,
// and reports results once WINDOW samples have been issued since a flush.
//   clk, reset      : clock, synchronous active-high reset
//   i_ch_sel/_load  : channel switch request and its one-cycle strobe
//   i_ch_valid/data : per-channel samples; o_ch_ready one-hot to active channel
//   o_avg_clr/en/din, i_avg_q : averager control, sample and result
//   o_res_valid/data/ch       : averaged result strobe, value, channel
//   o_sample_miss   : tick dropped because the sequencer was busy
module avg_channel_sequencer
   import avg_seq_pkg::*;
#(
   parameter int unsigned N      = 32,
   parameter int unsigned CH     = 4,
   parameter int unsigned WINDOW = 256,
   parameter int unsigned DIV    = 1000,
   parameter int unsigned LAT    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [$clog2(CH)-1:0]  i_ch_sel,
   input  logic                   i_ch_sel_load,
   input  logic [CH-1:0]          i_ch_valid,
   input  logic [CH*N-1:0]        i_ch_data,
   output logic [CH-1:0]          o_ch_ready,
   output logic                   o_avg_clr,
   output logic                   o_avg_en,
   output logic [N-1:0]           o_avg_din,
   input  logic [N-1:0]           i_avg_q,
   output logic                   o_res_valid,
   output logic [N-1:0]           o_res_data,
   output logic [$clog2(CH)-1:0]  o_res_ch,
   output logic                   o_sample_miss
);

   localparam int unsigned CHW = fld_w(CH);
   localparam int unsigned WCW = fld_w(WINDOW + 1);
   localparam int unsigned SCW = fld_w(LAT);

   if (CH < 2 || LAT < 1 || DIV <= LAT + 3) begin : g_param_err
      $error("avg_channel_sequencer: need CH>=2, LAT>=1 and DIV>LAT+3");
   end

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CHW-1:0] r_active;
   logic [CHW-1:0] r_pend_ch;
   logic           r_pend;
   logic [WCW-1:0] r_warm;
   logic [SCW-1:0] r_settle;
   logic [N-1:0]   r_sample;
   logic           r_res_valid;
   logic [N-1:0]   r_res_data;
   logic [CHW-1:0] r_res_ch;

   logic           w_tick;
   logic           w_load_ok;
   logic           w_settle_last;
   logic           w_active_valid;
   logic [N-1:0]   w_active_data;
   logic           w_xfer;
   logic           w_clr_c;
   logic           w_en_c;
   logic           w_ready_c;
   logic           w_miss_c;

   tick_divider #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   // Out-of-range or same-channel requests are dropped.
   assign w_load_ok      = i_ch_sel_load && (32'(i_ch_sel) < CH) && (i_ch_sel != r_active);
   assign w_settle_last  = (r_settle == SCW'(LAT - 1));
   assign w_active_valid = i_ch_valid[r_active];
   assign w_active_data  = i_ch_data[32'(r_active) * N +: N];

   // Next-state and strobe decode; a tick is a miss unless WAIT_TICK consumes it.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_c     = 1'b0;
      w_en_c      = 1'b0;
      w_ready_c   = 1'b0;
      w_xfer      = 1'b0;
      w_miss_c    = w_tick;
      case (r_state)
         FLUSH: begin
            w_clr_c     = 1'b1;
            w_state_nxt = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (w_load_ok) begin
               w_state_nxt = FLUSH;
            end else if (w_tick) begin
               w_miss_c    = 1'b0;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (w_load_ok) begin
               w_state_nxt = FLUSH;
            end else begin
               w_ready_c = 1'b1;
               if (w_active_valid) begin
                  w_xfer      = 1'b1;
                  w_state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            w_en_c      = 1'b1;
            w_state_nxt = SETTLE;
         end
         SETTLE: begin
            if (w_settle_last)
               w_state_nxt = (r_pend || w_load_ok) ? FLUSH : WAIT_TICK;
         end
         default: w_state_nxt = FLUSH;
      endcase
   end

   // State, pending switch, warm-up and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= FLUSH;
         r_active    <= '0;
         r_pend      <= 1'b0;
         r_pend_ch   <= '0;
         r_warm      <= '0;
         r_settle    <= '0;
         r_sample    <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_ch    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_res_valid <= 1'b0;
         if (w_load_ok) begin
            r_pend    <= 1'b1;
            r_pend_ch <= i_ch_sel;
         end
         case (r_state)
            FLUSH: begin
               // A request arriving during FLUSH is applied directly.
               r_warm <= '0;
               r_pend <= 1'b0;
               if (w_load_ok)
                  r_active <= i_ch_sel;
               else if (r_pend)
                  r_active <= r_pend_ch;
            end
            FETCH: begin
               if (w_xfer)
                  r_sample <= w_active_data;
            end
            ISSUE: begin
               r_settle <= '0;
               if (r_warm != WCW'(WINDOW))
                  r_warm <= r_warm + WCW'(1);
            end
            SETTLE: begin
               r_settle <= r_settle + SCW'(1);
               if (w_settle_last) begin
                  r_res_valid <= (r_warm == WCW'(WINDOW));
                  r_res_data  <= i_avg_q;
                  r_res_ch    <= r_active;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes are decodes of the state register, held low during reset.
   assign o_ch_ready    = (w_ready_c && !reset) ? (CH'(1) << r_active) : '0;
   assign o_avg_clr     = w_clr_c  && !reset;
   assign o_avg_en      = w_en_c   && !reset;
   assign o_sample_miss = w_miss_c && !reset;
   assign o_avg_din     = r_sample;
   assign o_res_valid   = r_res_valid;
   assign o_res_data    = r_res_data;
   assign o_res_ch      = r_res_ch;

endmodule
